// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator computer: owns pc, ir and latched ALU flags.
// Optional macro SEQ_RETIRE_COUNT_EN adds a 16-bit retired-instruction counter output.
module cpu_sequencer #(
   parameter int                PC_W     = 8,
   parameter int                IW       = 16,
   parameter logic [PC_W-1:0]   PC_RESET = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              step,
   input  logic [IW-1:0]     im_data,
   input  logic              la_req,
   input  logic              lb_req,
   input  logic              alu_z,
   input  logic              alu_n,
   input  logic              alu_c,
   input  logic              alu_v,
   output logic [PC_W-1:0]   pc,
   output logic [6:0]        opcode,
   output logic [7:0]        k,
   output logic              LA,
   output logic              LB,
   output logic [3:0]        flags,
   output logic [2:0]        state,
   output logic              halted
`ifdef SEQ_RETIRE_COUNT_EN
   ,
   output logic [15:0]       retired
`endif
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXECUTE = 3'd3,
      S_HALT    = 3'd4
   } state_t;

   localparam logic [6:0] OP_JMP = 7'h40;
   localparam logic [6:0] OP_JEQ = 7'h41;
   localparam logic [6:0] OP_JNE = 7'h42;
   localparam logic [6:0] OP_JGT = 7'h43;
   localparam logic [6:0] OP_JLT = 7'h44;
   localparam logic [6:0] OP_JCR = 7'h45;
   localparam logic [6:0] OP_HLT = 7'h7F;

   state_t            st, st_nxt;
   logic [IW-1:0]     ir;
   logic [3:0]        flags_r;
   logic              single_r;
   logic              is_jump;
   logic              is_hlt;
   logic              taken;
   logic              unused_ir8;

   assign opcode     = ir[15:9];
   assign k          = ir[7:0];
   assign unused_ir8 = ir[8];
   assign flags      = flags_r;
   assign state      = st;
   assign halted     = (st == S_HALT);

   assign is_jump = (opcode >= OP_JMP) && (opcode <= OP_JCR);
   assign is_hlt  = (opcode == OP_HLT);

   // Conditions read the latched flags {Z,N,C,V}, i.e. the last non-jump result.
   always_comb begin
      taken = 1'b0;
      case (opcode)
         OP_JMP:  taken = 1'b1;
         OP_JEQ:  taken = flags_r[3];
         OP_JNE:  taken = !flags_r[3];
         OP_JGT:  taken = !flags_r[3] && !flags_r[2];
         OP_JLT:  taken = flags_r[2];
         OP_JCR:  taken = flags_r[1];
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      st_nxt = st;
      LA     = 1'b0;
      LB     = 1'b0;
      case (st)
         S_IDLE:    if (run || step) st_nxt = S_FETCH;
         S_FETCH:   st_nxt = S_DECODE;
         S_DECODE:  st_nxt = S_EXECUTE;
         S_EXECUTE: begin
            LA = la_req && !is_jump;
            LB = lb_req && !is_jump;
            if (is_hlt)
               st_nxt = S_HALT;
            else if (run && !single_r)
               st_nxt = S_FETCH;
            else
               st_nxt = S_IDLE;
         end
         S_HALT:    st_nxt = S_HALT;
         default:   st_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= S_IDLE;
         pc       <= PC_RESET;
         ir       <= '0;
         flags_r  <= '0;
         single_r <= 1'b0;
      end else begin
         st <= st_nxt;
         // run wins over step, so single-step mode only when run is low.
         if (st == S_IDLE && (run || step))
            single_r <= !run;
         if (st == S_FETCH)
            ir <= im_data;
         if (st == S_EXECUTE) begin
            if (!is_hlt)
               pc <= taken ? PC_W'(k) : pc + PC_W'(1);
            if (!is_jump && !is_hlt)
               flags_r <= {alu_z, alu_n, alu_c, alu_v};
         end
      end
   end

`ifdef SEQ_RETIRE_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retired <= '0;
      else if (st == S_EXECUTE)
         retired <= retired + 16'd1;
   end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: random programs and run/step/flag stimulus against an instruction-level model.
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0, step = 1'b0;
   logic        la_req = 1'b0, lb_req = 1'b0;
   logic        alu_z = 1'b0, alu_n = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
   logic [15:0] im_data;
   logic [7:0]  pc;
   logic [6:0]  opcode;
   logic [7:0]  k;
   logic        LA, LB;
   logic [3:0]  flags;
   logic [2:0]  state;
   logic        halted;
`ifdef SEQ_RETIRE_COUNT_EN
   logic [15:0] retired;
`endif

   logic [15:0] imem [256];
   assign im_data = imem[pc];

   cpu_sequencer dut (
      .clk(clk), .rst_n(rst_n), .run(run), .step(step), .im_data(im_data),
      .la_req(la_req), .lb_req(lb_req),
      .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
      .pc(pc), .opcode(opcode), .k(k), .LA(LA), .LB(LB), .flags(flags),
      .state(state), .halted(halted)
`ifdef SEQ_RETIRE_COUNT_EN
      , .retired(retired)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  st;
      logic [7:0]  pc;
      logic [6:0]  op;
      logic [7:0]  k;
      logic        la;
      logic        lb;
      logic [3:0]  fl;
      logic        hl;
      logic [15:0] ret;
   } rec_t;
   localparam int REC_W = $bits(rec_t);

   logic [REC_W-1:0] exp_q[$];
   int n_chk = 0, n_fail = 0, n_push = 0, n_pop = 0;

   // Instruction-level reference: an instruction is in flight for three clocks and retires on the third.
   logic        m_busy, m_halt, m_single;
   int          m_cyc;
   logic [7:0]  m_pc;
   logic [15:0] m_ir;
   logic [3:0]  m_flags;
   logic [15:0] m_ret;
   logic        force_la;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic is_jmp_op(input logic [6:0] op);
      return (op >= 7'h40) && (op <= 7'h45);
   endfunction

   function automatic logic jump_taken(input logic [6:0] op, input logic [3:0] fl);
      logic z, n, c;
      z = fl[3]; n = fl[2]; c = fl[1];
      case (op)
         7'h40:   return 1'b1;
         7'h41:   return z;
         7'h42:   return !z;
         7'h43:   return !z && !n;
         7'h44:   return n;
         7'h45:   return c;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [15:0] rand_instr();
      logic [6:0] op;
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)      op = 7'($urandom_range(0, 63));
      else if (r < 9) op = 7'(7'h40 + $urandom_range(0, 5));
      else            op = 7'($urandom_range(7'h46, 7'h7E));
      return {op, 1'($urandom), 8'($urandom)};
   endfunction

   function automatic logic [15:0] nonjump_instr();
      return {7'($urandom_range(0, 63)), 1'b0, 8'($urandom)};
   endfunction

   task automatic fill_prog();
      for (int i = 0; i < 256; i++) imem[i] = rand_instr();
   endtask

   task automatic model_reset();
      m_busy = 0; m_halt = 0; m_single = 0; m_cyc = 0;
      m_pc = 8'h00; m_ir = 16'h0; m_flags = 4'h0; m_ret = 16'h0;
   endtask

   // Advance one clock using the inputs that were present before the edge.
   task automatic model_edge();
      logic [6:0] op;
      if (m_halt) return;
      if (!m_busy) begin
         if (run || step) begin
            m_busy = 1; m_cyc = 0; m_single = !run;
         end
         return;
      end
      if (m_cyc == 0) begin
         m_ir = imem[m_pc]; m_cyc = 1;
      end else if (m_cyc == 1) begin
         m_cyc = 2;
      end else begin
         op = m_ir[15:9];
         m_ret = m_ret + 16'd1;
         if (op == 7'h7F) begin
            m_halt = 1; m_busy = 0;
         end else begin
            if (is_jmp_op(op)) begin
               m_pc = jump_taken(op, m_flags) ? m_ir[7:0] : m_pc + 8'd1;
            end else begin
               m_pc = m_pc + 8'd1;
               m_flags = {alu_z, alu_n, alu_c, alu_v};
            end
            m_busy = run && !m_single;
         end
         m_cyc = 0;
      end
   endtask

   function automatic rec_t model_out();
      rec_t r;
      logic exe;
      exe = m_busy && (m_cyc == 2);
      r.st  = m_halt ? 3'd4 : (!m_busy ? 3'd0 : 3'(m_cyc + 1));
      r.pc  = m_pc;
      r.op  = m_ir[15:9];
      r.k   = m_ir[7:0];
      r.la  = exe && !is_jmp_op(m_ir[15:9]) && la_req;
      r.lb  = exe && !is_jmp_op(m_ir[15:9]) && lb_req;
      r.fl  = m_flags;
      r.hl  = m_halt;
      r.ret = m_ret;
      return r;
   endfunction

   task automatic push_exp();
      exp_q.push_back(REC_W'(model_out()));
      n_push++;
   endtask

   // mode 0: run held high; 1: step pulses only; 2: run toggling with steps.
   task automatic gen_inputs(input int mode);
      case (mode)
         0: begin run = 1'b1; step = 1'b0; end
         1: begin run = 1'b0; step = ($urandom_range(0, 3) == 0); end
         default: begin
            if ($urandom_range(0, 7) == 0) run = ~run;
            step = ($urandom_range(0, 5) == 0);
         end
      endcase
      la_req = force_la ? 1'b1 : 1'($urandom);
      lb_req = force_la ? 1'b0 : 1'($urandom);
      {alu_z, alu_n, alu_c, alu_v} = 4'($urandom);
   endtask

   task automatic cycle(input int mode);
      @(posedge clk); #1;
      model_edge();
      gen_inputs(mode);
      push_exp();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      model_reset();
      run = 0; step = 0; la_req = 0; lb_req = 0;
      {alu_z, alu_n, alu_c, alu_v} = 4'h0;
      push_exp();
      @(posedge clk); #1;
      rst_n = 1'b1;
      push_exp();
   endtask

   rec_t mon_e;
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = rec_t'(exp_q.pop_front());
         n_pop++;
         chk("state",  32'(state),  32'(mon_e.st));
         chk("pc",     32'(pc),     32'(mon_e.pc));
         chk("opcode", 32'(opcode), 32'(mon_e.op));
         chk("k",      32'(k),      32'(mon_e.k));
         chk("LA",     32'(LA),     32'(mon_e.la));
         chk("LB",     32'(LB),     32'(mon_e.lb));
         chk("flags",  32'(flags),  32'(mon_e.fl));
         chk("halted", 32'(halted), 32'(mon_e.hl));
`ifdef SEQ_RETIRE_COUNT_EN
         chk("retired", 32'(retired), 32'(mon_e.ret));
`endif
      end
   end

   initial begin
      int guard;
      force_la = 1'b0;
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
      model_reset();
      #2;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_pc", 32'(pc), 32'h00);
      chk("reset_LA_LB", 32'({LA, LB}), 32'd0);
      chk("reset_halted", 32'(halted), 32'd0);

      // LA-type op then HLT: LA pulses once in EXECUTE, then halt at pc 1.
      imem[0] = {7'h01, 1'b0, 8'h00};
      imem[1] = {7'h7F, 1'b0, 8'h00};
      force_la = 1'b1;
      do_reset();
      for (int i = 0; i < 30; i++) cycle(0);
      #5;
      chk("ep1_halted", 32'(halted), 32'd1);
      chk("ep1_pc_held", 32'(pc), 32'h01);
      force_la = 1'b0;

      // Random program with JMP at 5 and JEQ at 0x21.
      fill_prog();
      for (int i = 0; i < 5; i++) imem[i] = nonjump_instr();
      imem[5]    = {7'h40, 1'b0, 8'h20};
      imem[8'h20] = nonjump_instr();
      imem[8'h21] = {7'h41, 1'b0, 8'h10};
      do_reset();
      for (int i = 0; i < 300; i++) cycle(0);

      // pc wrap from 8'hFF.
      fill_prog();
      imem[0]     = {7'h40, 1'b0, 8'hFF};
      imem[8'hFF] = nonjump_instr();
      do_reset();
      for (int i = 0; i < 30; i++) cycle(0);

      // Single-step and mixed run/step.
      fill_prog();
      do_reset();
      for (int i = 0; i < 400; i++) cycle(1);
      do_reset();
      for (int i = 0; i < 400; i++) cycle(2);

      // Reset asserted in the middle of DECODE.
      fill_prog();
      do_reset();
      for (int i = 0; i < 10; i++) cycle(0);
      guard = 0;
      while (!(m_busy && m_cyc == 1) && guard < 20) begin
         cycle(0);
         guard++;
      end
      chk("decode_reached", 32'(guard < 20), 32'd1);
      #5;
      rst_n = 1'b0;
      #1;
      chk("midreset_state", 32'(state), 32'd0);
      chk("midreset_pc", 32'(pc), 32'h00);
      chk("midreset_LA_LB", 32'({LA, LB}), 32'd0);
      chk("midreset_flags", 32'(flags), 32'h0);
      model_reset();
      do_reset();
      for (int i = 0; i < 20; i++) cycle(0);

      // Four instructions then HLT, then sit halted.
      fill_prog();
      for (int i = 0; i < 4; i++) imem[i] = nonjump_instr();
      imem[4] = {7'h7F, 1'b0, 8'h00};
      do_reset();
      for (int i = 0; i < 35; i++) cycle(2);
      #5;
      chk("ep7_halted", 32'(halted), 32'd1);
      chk("ep7_pc", 32'(pc), 32'h04);
`ifdef SEQ_RETIRE_COUNT_EN
      chk("ep7_retired", 32'(retired), 32'd5);
`endif

      @(posedge clk); #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("records_checked", 32'(n_pop), 32'(n_push));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
